axi_lite_arb2: RTL and testbench
================================

AXI_LITE_ARB2 -- requirements
Module: axi_lite_arb2

Interface
REQ-001 Parameter AW, default 32, address width of all AXI4-Lite ports.
REQ-002 Parameter DW, default 32, data width of all ports; strobe width is DW/8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 m0_axi_{awaddr,awprot,awvalid,wdata,wstrb,wvalid,bready,araddr,arprot,arvalid,rready}  input  AW/3/1/DW/DW/8/1/1/AW/3/1/1  master 0 (core data port) requests.
REQ-006 m0_axi_{awready,wready,bresp,bvalid,arready,rdata,rresp,rvalid}  output  1/1/2/1/1/DW/2/1  master 0 responses.
REQ-007 m1_axi_* same signal set, widths and directions as m0  master 1 (debug/loader port).
REQ-008 s_axi_* mirror of the master set, directions reversed  shared slave (IRAM).
REQ-009 gnt_o  output  2  one-hot current owner ({m1,m0}); 2'b00 when idle.

Function
REQ-010 FSM states IDLE, WR, RD; exactly one AXI-Lite transaction in flight at any time.
REQ-011 Master i requests when awvalid_i or arvalid_i is 1; wvalid alone is not a request.
REQ-012 In IDLE with requests pending, grant is registered: owner and next state take effect the cycle after requests are sampled (1-cycle arbitration latency).
REQ-013 Round-robin: priority pointer starts at m0; after a transaction completes, the pointer selects the other master.
REQ-014 Single requester is granted regardless of pointer.
REQ-015 If the granted master asserts awvalid and arvalid together, write is taken (IDLE->WR); its read waits for the next arbitration.
REQ-016 WR: owner's AW, W and B channels connect combinationally to the slave; exit to IDLE on s_axi_bvalid & owner bready in the same cycle.
REQ-017 RD: owner's AR and R channels connect combinationally to the slave; exit to IDLE on s_axi_rvalid & owner rready.
REQ-018 AW and W may complete in either order or the same cycle; once accepted, the arbiter blocks re-presentation of that channel to the slave (per-channel done flags) until B completes.
REQ-019 AR is blocked after its handshake in the same way until R completes.
REQ-020 Non-owner outputs: all ready, bvalid, rvalid = 0; rdata, bresp, rresp = 0.
REQ-021 In IDLE all slave valids and master readies/valids are 0; the slave never sees a valid without a registered owner.
REQ-022 awprot/arprot, addr, data and strb pass unmodified; no address decode, no response generation.
REQ-023 Master valids asserted during another master's transaction are held by that master (AXI rule) and arbitrated at the next IDLE.
REQ-024 Back-to-back: completion cycle returns to IDLE; the next grant is registered one cycle later (minimum 1 idle cycle between transactions).

Reset
REQ-025 rst_n=0 forces state IDLE, pointer=m0, gnt_o=00, done flags cleared, all valid/ready outputs 0, immediately and asynchronously.
REQ-026 Reset during WR/RD abandons the transaction; no response is generated to either master after release.
REQ-027 First arbitration occurs on the first rising edge after rst_n deasserts.

Verification
REQ-028 m0 read only, addr 0x10, slave rdata 0xDEADBEEF after 2 cycles -> gnt_o=01 one cycle after arvalid, m0 rdata=0xDEADBEEF rresp=0, m1 rvalid stays 0.
REQ-029 m0 and m1 both arvalid same cycle from reset -> m0 served first, then m1; repeat with both again -> order m1 is next after m0 (alternation m0,m1,m0,m1 over 4 transactions).
REQ-030 m1 write addr 0x20 data 0x12345678 strb 0xF, wvalid 3 cycles before awvalid -> single slave AW and W handshake each, one B to m1, gnt_o returns to 00 one cycle after bvalid&bready.
REQ-031 m0 awvalid+arvalid together, m1 idle -> write completes first, then read granted after 1 idle cycle.
REQ-032 Slave bvalid held with m0 bready=0 for 5 cycles while m1 arvalid=1 -> m1 arready stays 0 until m0 B handshake, then m1 granted.
REQ-033 rst_n pulsed low mid-RD with slave rvalid pending -> all outputs 0 during reset, gnt_o=00, no rvalid to either master after release.

Source files
------------

// File: rtl/axi_lite_arb2_if.sv
// One AXI4-Lite port (AW, W, B, AR, R channels). The master modport drives
// requests; the slave modport drives responses.
interface axi_lite_arb2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_arb2.sv
// Two-master round-robin arbiter onto one AXI4-Lite slave, one transaction in
// flight; state_o exposes the FSM state (0 IDLE, 1 WR, 2 RD).
module axi_lite_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_lite_arb2_if.slave        m0_axi,
  axi_lite_arb2_if.slave        m1_axi,
  axi_lite_arb2_if.master       s_axi,
  output logic [1:0]            gnt_o,
  output logic [1:0]            state_o
);

  // Handshakes: a channel transfers on a rising edge where valid & ready are
  // both 1; valid, once raised, is held until that edge.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WR = 2'd1, ST_RD = 2'd2} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   ptr_q, ptr_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ar_done_q, ar_done_d;
  logic   pick;

  logic req0, req1, in_wr, in_rd, b_done, r_done;

  logic [AW-1:0]   own_awaddr, own_araddr;
  logic [2:0]      own_awprot, own_arprot;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_wstrb;
  logic            own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;

  logic            rsp_awready, rsp_wready, rsp_bvalid, rsp_arready, rsp_rvalid;
  logic [1:0]      rsp_bresp, rsp_rresp;
  logic [DW-1:0]   rsp_rdata;

  assign req0  = m0_axi.awvalid | m0_axi.arvalid;
  assign req1  = m1_axi.awvalid | m1_axi.arvalid;
  assign in_wr = (state_q == ST_WR);
  assign in_rd = (state_q == ST_RD);

  assign own_awaddr  = owner_q ? m1_axi.awaddr  : m0_axi.awaddr;
  assign own_awprot  = owner_q ? m1_axi.awprot  : m0_axi.awprot;
  assign own_awvalid = owner_q ? m1_axi.awvalid : m0_axi.awvalid;
  assign own_wdata   = owner_q ? m1_axi.wdata   : m0_axi.wdata;
  assign own_wstrb   = owner_q ? m1_axi.wstrb   : m0_axi.wstrb;
  assign own_wvalid  = owner_q ? m1_axi.wvalid  : m0_axi.wvalid;
  assign own_bready  = owner_q ? m1_axi.bready  : m0_axi.bready;
  assign own_araddr  = owner_q ? m1_axi.araddr  : m0_axi.araddr;
  assign own_arprot  = owner_q ? m1_axi.arprot  : m0_axi.arprot;
  assign own_arvalid = owner_q ? m1_axi.arvalid : m0_axi.arvalid;
  assign own_rready  = owner_q ? m1_axi.rready  : m0_axi.rready;

  // Done flags keep an accepted channel from being presented to the slave twice.
  assign s_axi.awaddr  = own_awaddr;
  assign s_axi.awprot  = own_awprot;
  assign s_axi.awvalid = in_wr & own_awvalid & ~aw_done_q;
  assign s_axi.wdata   = own_wdata;
  assign s_axi.wstrb   = own_wstrb;
  assign s_axi.wvalid  = in_wr & own_wvalid & ~w_done_q;
  assign s_axi.bready  = in_wr & own_bready;
  assign s_axi.araddr  = own_araddr;
  assign s_axi.arprot  = own_arprot;
  assign s_axi.arvalid = in_rd & own_arvalid & ~ar_done_q;
  assign s_axi.rready  = in_rd & own_rready;

  assign rsp_awready = in_wr & s_axi.awready & ~aw_done_q;
  assign rsp_wready  = in_wr & s_axi.wready & ~w_done_q;
  assign rsp_bvalid  = in_wr & s_axi.bvalid;
  assign rsp_bresp   = in_wr ? s_axi.bresp : 2'b00;
  assign rsp_arready = in_rd & s_axi.arready & ~ar_done_q;
  assign rsp_rvalid  = in_rd & s_axi.rvalid;
  assign rsp_rdata   = in_rd ? s_axi.rdata : '0;
  assign rsp_rresp   = in_rd ? s_axi.rresp : 2'b00;

  assign b_done = in_wr & s_axi.bvalid & own_bready;
  assign r_done = in_rd & s_axi.rvalid & own_rready;

  assign m0_axi.awready = ~owner_q & rsp_awready;
  assign m0_axi.wready  = ~owner_q & rsp_wready;
  assign m0_axi.bvalid  = ~owner_q & rsp_bvalid;
  assign m0_axi.bresp   = owner_q ? 2'b00 : rsp_bresp;
  assign m0_axi.arready = ~owner_q & rsp_arready;
  assign m0_axi.rvalid  = ~owner_q & rsp_rvalid;
  assign m0_axi.rdata   = owner_q ? '0 : rsp_rdata;
  assign m0_axi.rresp   = owner_q ? 2'b00 : rsp_rresp;

  assign m1_axi.awready = owner_q & rsp_awready;
  assign m1_axi.wready  = owner_q & rsp_wready;
  assign m1_axi.bvalid  = owner_q & rsp_bvalid;
  assign m1_axi.bresp   = owner_q ? rsp_bresp : 2'b00;
  assign m1_axi.arready = owner_q & rsp_arready;
  assign m1_axi.rvalid  = owner_q & rsp_rvalid;
  assign m1_axi.rdata   = owner_q ? rsp_rdata : '0;
  assign m1_axi.rresp   = owner_q ? rsp_rresp : 2'b00;

  assign gnt_o   = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign state_o = state_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    pick      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          // Contention resolves by the pointer; a lone requester always wins.
          pick    = (req0 & req1) ? ptr_q : req1;
          owner_d = pick;
          state_d = (pick ? m1_axi.awvalid : m0_axi.awvalid) ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | (s_axi.awvalid & s_axi.awready);
        w_done_d  = w_done_q | (s_axi.wvalid & s_axi.wready);
        if (b_done) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ptr_d     = ~owner_q;
        end
      end
      ST_RD: begin
        ar_done_d = ar_done_q | (s_axi.arvalid & s_axi.arready);
        if (r_done) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
          ptr_d     = ~owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: master/slave driver tasks, a negedge
// monitor logging grants and protocol counts, immediate-assertion checks.
module tb_axi_lite_arb2;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] gnt, state;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_arb2_if #(.AW(32), .DW(32)) m0_if ();
  axi_lite_arb2_if #(.AW(32), .DW(32)) m1_if ();
  axi_lite_arb2_if #(.AW(32), .DW(32)) s_if ();

  axi_lite_arb2 #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .m0_axi(m0_if), .m1_axi(m1_if), .s_axi(s_if),
    .gnt_o(gnt), .state_o(state)
  );

  logic [31:0] m_awaddr[2], m_wdata[2], m_araddr[2], m_rdata[2];
  logic [3:0]  m_wstrb[2];
  logic        m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
  logic        m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
  logic [1:0]  m_bresp[2], m_rresp[2];

  assign m0_if.awaddr = m_awaddr[0];  assign m1_if.awaddr = m_awaddr[1];
  assign m0_if.awprot = 3'd1;         assign m1_if.awprot = 3'd2;
  assign m0_if.awvalid = m_awvalid[0]; assign m1_if.awvalid = m_awvalid[1];
  assign m0_if.wdata = m_wdata[0];    assign m1_if.wdata = m_wdata[1];
  assign m0_if.wstrb = m_wstrb[0];    assign m1_if.wstrb = m_wstrb[1];
  assign m0_if.wvalid = m_wvalid[0];  assign m1_if.wvalid = m_wvalid[1];
  assign m0_if.bready = m_bready[0];  assign m1_if.bready = m_bready[1];
  assign m0_if.araddr = m_araddr[0];  assign m1_if.araddr = m_araddr[1];
  assign m0_if.arprot = 3'd1;         assign m1_if.arprot = 3'd2;
  assign m0_if.arvalid = m_arvalid[0]; assign m1_if.arvalid = m_arvalid[1];
  assign m0_if.rready = m_rready[0];  assign m1_if.rready = m_rready[1];

  assign m_awready[0] = m0_if.awready; assign m_awready[1] = m1_if.awready;
  assign m_wready[0] = m0_if.wready;   assign m_wready[1] = m1_if.wready;
  assign m_bvalid[0] = m0_if.bvalid;   assign m_bvalid[1] = m1_if.bvalid;
  assign m_bresp[0] = m0_if.bresp;     assign m_bresp[1] = m1_if.bresp;
  assign m_arready[0] = m0_if.arready; assign m_arready[1] = m1_if.arready;
  assign m_rvalid[0] = m0_if.rvalid;   assign m_rvalid[1] = m1_if.rvalid;
  assign m_rdata[0] = m0_if.rdata;     assign m_rdata[1] = m1_if.rdata;
  assign m_rresp[0] = m0_if.rresp;     assign m_rresp[1] = m1_if.rresp;

  // Monitor: samples between the negedge drive point and the next posedge.
  int s_aw_hs = 0, s_w_hs = 0, s_ar_hs = 0, b_hs_cyc = 0;
  int rv_cnt[2] = '{0, 0};
  int bv_cnt[2] = '{0, 0};
  int idle_viol = 0, nonown_viol = 0, idle_run = 0;
  int req_cyc[2] = '{0, 0};
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] gnt_log[$];
  logic [1:0] st_log[$];
  int gcyc_log[$];
  int gap_log[$];

  always begin
    @(negedge clk);
    #2;
    if (s_if.awvalid && s_if.awready) s_aw_hs++;
    if (s_if.wvalid && s_if.wready) s_w_hs++;
    if (s_if.arvalid && s_if.arready) s_ar_hs++;
    if (s_if.bvalid && s_if.bready) b_hs_cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      if (m_rvalid[i]) rv_cnt[i]++;
      if (m_bvalid[i]) bv_cnt[i]++;
      if (!gnt[i] && (m_awready[i] || m_wready[i] || m_bvalid[i] || m_arready[i] ||
          m_rvalid[i] || (|m_rdata[i]) || (|m_bresp[i]) || (|m_rresp[i])))
        nonown_viol++;
    end
    if (gnt == 2'b00) begin
      if (s_if.awvalid || s_if.wvalid || s_if.arvalid || s_if.bready || s_if.rready)
        idle_viol++;
      idle_run++;
    end else if (gnt != prev_gnt) begin
      gnt_log.push_back(gnt);
      st_log.push_back(state);
      gcyc_log.push_back(cyc);
      gap_log.push_back(idle_run);
      idle_run = 0;
    end
    prev_gnt = gnt;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_read(input int m, input logic [31:0] addr,
                        output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    m_araddr[m] = addr; m_arvalid[m] = 1'b1; m_rready[m] = 1'b1; req_cyc[m] = cyc;
    #1;
    while (!m_arready[m] && n < TMO) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    m_arvalid[m] = 1'b0; m_araddr[m] = '0;
    #1;
    while (!m_rvalid[m] && n < TMO) begin @(negedge clk); #1; n++; end
    data = m_rdata[m]; resp = m_rresp[m];
    @(negedge clk);
    m_rready[m] = 1'b0;
    chk("m_rd_timeout", n < TMO, 1);
  endtask

  task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int w_lead, input int b_delay,
                         output logic [1:0] resp);
    int n;
    logic aw_ok, w_ok, hs_aw, hs_w;
    n = 0; aw_ok = 1'b0; w_ok = 1'b0;
    m_wdata[m] = data; m_wstrb[m] = strb; m_wvalid[m] = 1'b1; m_bready[m] = 1'b0;
    repeat (w_lead) @(negedge clk);
    m_awaddr[m] = addr; m_awvalid[m] = 1'b1; req_cyc[m] = cyc;
    while (!(aw_ok && w_ok) && n < TMO) begin
      #1;
      hs_aw = m_awvalid[m] && m_awready[m];
      hs_w  = m_wvalid[m] && m_wready[m];
      @(negedge clk);
      n++;
      if (hs_aw) begin m_awvalid[m] = 1'b0; aw_ok = 1'b1; end
      if (hs_w) begin m_wvalid[m] = 1'b0; w_ok = 1'b1; end
    end
    repeat (b_delay) @(negedge clk);
    m_bready[m] = 1'b1;
    #1;
    while (!m_bvalid[m] && n < TMO) begin @(negedge clk); #1; n++; end
    resp = m_bresp[m];
    @(negedge clk);
    m_bready[m] = 1'b0;
    chk("m_wr_timeout", n < TMO, 1);
  endtask

  task automatic s_read(input logic [31:0] data, input logic [1:0] resp, input int lat,
                        output logic [31:0] addr);
    int n;
    n = 0;
    #1;
    while (!(s_if.arvalid && s_if.arready) && n < TMO) begin @(negedge clk); #1; n++; end
    addr = s_if.araddr;
    @(negedge clk);
    repeat (lat) @(negedge clk);
    s_if.rvalid = 1'b1; s_if.rdata = data; s_if.rresp = resp;
    #1;
    while (!s_if.rready && n < TMO) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
    chk("s_rd_timeout", n < TMO, 1);
  endtask

  task automatic s_write(input logic [1:0] resp, input int lat, output logic [31:0] addr,
                         output logic [31:0] data, output logic [3:0] strb);
    int n;
    logic aw_ok, w_ok, hs_aw, hs_w;
    n = 0; aw_ok = 1'b0; w_ok = 1'b0; addr = '0; data = '0; strb = '0;
    while (!(aw_ok && w_ok) && n < TMO) begin
      #1;
      hs_aw = s_if.awvalid && s_if.awready;
      hs_w  = s_if.wvalid && s_if.wready;
      if (hs_aw) addr = s_if.awaddr;
      if (hs_w) begin data = s_if.wdata; strb = s_if.wstrb; end
      @(negedge clk);
      n++;
      if (hs_aw) aw_ok = 1'b1;
      if (hs_w) w_ok = 1'b1;
    end
    repeat (lat) @(negedge clk);
    s_if.bvalid = 1'b1; s_if.bresp = resp;
    #1;
    while (!s_if.bready && n < TMO) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    chk("s_wr_timeout", n < TMO, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0a, d0b, d1a, d1b, a0, a1, a2, a3, sa, sd;
    logic [3:0]  ss;
    logic [1:0]  r0, r1, br;
    int base, aw0, w0, bv0, bv1, rv0, rv1;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_wdata[i] = '0; m_araddr[i] = '0; m_wstrb[i] = '0;
      m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
      m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
    end
    s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.arready = 1'b1;
    s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
    m_arvalid[0] = 1'b1;

    // Reset with a request present: nothing may reach the slave.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_state", state, 2'd0);
    chk("rst_s_arvalid", s_if.arvalid, 1'b0);
    chk("rst_m0_arready", m_arready[0], 1'b0);
    @(negedge clk);
    m_arvalid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single m0 read, slave answers two cycles after AR.
    base = gnt_log.size(); rv1 = rv_cnt[1];
    fork
      m_read(0, 32'h10, d0a, r0);
      s_read(32'hDEADBEEF, 2'b00, 2, a0);
    join
    #1;
    chk("t1_rdata", d0a, 32'hDEADBEEF);
    chk("t1_rresp", r0, 2'b00);
    chk("t1_araddr", a0, 32'h10);
    chk("t1_m1_rvalid", rv_cnt[1] - rv1, 0);
    chk("t1_gnt", gnt_log[base], 2'b01);
    chk("t1_latency", gcyc_log[base] - req_cyc[0], 1);
    chk("t1_gnt_after", gnt, 2'b00);

    // Contention from reset: alternation m0, m1, m0, m1.
    do_reset();
    base = gnt_log.size();
    fork
      begin m_read(0, 32'h100, d0a, r0); m_read(0, 32'h104, d0b, r0); end
      begin m_read(1, 32'h200, d1a, r1); m_read(1, 32'h204, d1b, r1); end
      begin
        s_read(32'hA0, 2'b00, 1, a0); s_read(32'hA1, 2'b00, 1, a1);
        s_read(32'hA2, 2'b00, 1, a2); s_read(32'hA3, 2'b00, 1, a3);
      end
    join
    chk("t2_d0a", d0a, 32'hA0);
    chk("t2_d1a", d1a, 32'hA1);
    chk("t2_d0b", d0b, 32'hA2);
    chk("t2_d1b", d1b, 32'hA3);
    chk("t2_addr_seq", {a0[15:0], a1[15:0], a2[15:0], a3[15:0]}, 64'h0100_0200_0104_0204);
    chk("t2_ngnt", gnt_log.size() - base, 4);
    chk("t2_order", {gnt_log[base], gnt_log[base+1], gnt_log[base+2], gnt_log[base+3]},
        8'b01_10_01_10);
    chk("t2_gaps", {gap_log[base+1][3:0], gap_log[base+2][3:0], gap_log[base+3][3:0]},
        12'h111);

    // m1 write with W leading AW by three cycles.
    base = gnt_log.size(); aw0 = s_aw_hs; w0 = s_w_hs; bv0 = bv_cnt[0]; bv1 = bv_cnt[1];
    fork
      m_write(1, 32'h20, 32'h12345678, 4'hF, 3, 0, br);
      s_write(2'b00, 1, sa, sd, ss);
    join
    #1;
    chk("t3_gnt_after", gnt, 2'b00);
    chk("t3_aw_hs", s_aw_hs - aw0, 1);
    chk("t3_w_hs", s_w_hs - w0, 1);
    chk("t3_awaddr", sa, 32'h20);
    chk("t3_wdata", sd, 32'h12345678);
    chk("t3_wstrb", ss, 4'hF);
    chk("t3_bresp", br, 2'b00);
    chk("t3_m1_b", bv_cnt[1] - bv1, 1);
    chk("t3_m0_b", bv_cnt[0] - bv0, 0);
    chk("t3_gnt", gnt_log[base], 2'b10);
    chk("t3_latency", gcyc_log[base] - req_cyc[1], 1);

    // m0 presents AW and AR together: write first, read after one idle cycle.
    base = gnt_log.size();
    fork
      m_write(0, 32'h30, 32'hA5A5A5A5, 4'h3, 0, 0, br);
      m_read(0, 32'h34, d0a, r0);
      begin s_write(2'b00, 0, sa, sd, ss); s_read(32'h0BADF00D, 2'b00, 0, a0); end
    join
    chk("t4_ngnt", gnt_log.size() - base, 2);
    chk("t4_gnt", {gnt_log[base], gnt_log[base+1]}, 4'b01_01);
    chk("t4_states", {st_log[base], st_log[base+1]}, 4'b01_10);
    chk("t4_gap", gap_log[base+1], 1);
    chk("t4_wstrb", ss, 4'h3);
    chk("t4_rdata", d0a, 32'h0BADF00D);
    chk("t4_araddr", a0, 32'h34);

    // m0 stalls B for five cycles while m1 waits with a read.
    base = gnt_log.size(); bv0 = bv_cnt[0];
    fork
      m_write(0, 32'h40, 32'h55AA55AA, 4'hF, 0, 5, br);
      begin repeat (2) @(negedge clk); m_read(1, 32'h44, d1a, r1); end
      begin s_write(2'b10, 0, sa, sd, ss); s_read(32'hCAFE0001, 2'b01, 1, a1); end
    join
    chk("t5_bresp", br, 2'b10);
    chk("t5_b_cycles", bv_cnt[0] - bv0, 6);
    chk("t5_gnt", {gnt_log[base], gnt_log[base+1]}, 4'b01_10);
    chk("t5_m1_after_b", gcyc_log[base+1] - b_hs_cyc, 2);
    chk("t5_rdata", d1a, 32'hCAFE0001);
    chk("t5_rresp", r1, 2'b01);

    // Reset pulse while the slave holds R valid to a stalled m0.
    m_araddr[0] = 32'h50; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_gnt", gnt, 2'b01);
    chk("t6_s_arvalid", s_if.arvalid, 1'b1);
    @(negedge clk);
    m_arvalid[0] = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h5555AAAA;
    #1;
    chk("t6_m0_rvalid", m_rvalid[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_state", state, 2'd0);
    chk("t6_rst_rvalid", m_rvalid[0], 1'b0);
    chk("t6_rst_rdata", m_rdata[0], 32'h0);
    chk("t6_rst_rready", s_if.rready, 1'b0);
    rv0 = rv_cnt[0]; rv1 = rv_cnt[1];
    @(negedge clk);
    rst_n = 1'b1; m_rready[0] = 1'b1; m_rready[1] = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_no_r_m0", rv_cnt[0] - rv0, 0);
    chk("t6_no_r_m1", rv_cnt[1] - rv1, 0);
    chk("t6_gnt_after", gnt, 2'b00);
    s_if.rvalid = 1'b0; s_if.rdata = '0;
    m_rready[0] = 1'b0; m_rready[1] = 1'b0;
    @(negedge clk);

    chk("idle_outputs", idle_viol, 0);
    chk("nonowner_outputs", nonown_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
